stream_unary_reduce: RTL and testbench
======================================

Name: stream_unary_reduce

Overview:
Sequential, multi-beat unary reduction engine for the BasicCombinationalLogic Unary unit.
- Consumes an operand vector arriving as a framed stream of N-bit beats (valid/ready, last).
- Produces one registered reduction result per frame: AND, NAND, OR, NOR, XOR or XNOR over every bit of every beat.
- Sits where operands are wider than one bus word, e.g. zero-detect or parity over a packet payload, and hands the result downstream through its own valid/ready port.

Parameters:
N, 8, bits per input beat (N >= 1)
CW, 16, width of the frame beat counter / m_beats output (CW >= 2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
op  input  3  reduction select, sampled on the first beat of a frame: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6-7 reserved
s_valid  input  1  input beat valid
s_ready  output  1  input beat accepted when s_valid && s_ready
s_data  input  N  input beat data
s_last  input  1  final beat of the frame
m_valid  output  1  result valid
m_ready  input  1  downstream accepts the result when m_valid && m_ready
m_result  output  1  frame reduction result
m_beats  output  CW  beats in the frame, saturating at 2^CW-1
m_err  output  1  frame used a reserved op (m_result forced 0)

Behaviour:
- Single clock clk; reset is synchronous and active-high on rst. When rst=1 at a rising edge:
  - state <= IDLE.
  - m_valid, m_result and m_err <= 0; m_beats <= 0.
  - Accumulators cleared.
  - s_ready is 0 during the reset cycle and 1 from the first cycle after rst deasserts.
- States:
  - IDLE: no frame open. s_ready=1.
  - ACCUM: frame open. s_ready=1.
  - HOLD: result presented. s_ready=0, m_valid=1.
- Beat accept: a beat is accepted when s_valid && s_ready. No other input is sampled.
- IDLE, beat accepted:
  - Latch op into op_q.
  - Set and_acc=&s_data, or_acc=|s_data, xor_acc=^s_data, cnt=1.
  - If s_last=1, go to HOLD. Otherwise go to ACCUM.
- ACCUM, beat accepted:
  - and_acc &= &s_data; or_acc |= |s_data; xor_acc ^= ^s_data.
  - cnt increments and saturates at 2^CW-1 without wrapping.
  - If s_last=1, go to HOLD.
- Op sampling: op is sampled only on the first beat. Changes to op mid-frame are ignored.
- Entering HOLD: on the same edge, register the outputs.
  - m_valid=1, m_beats=cnt (including the last beat).
  - m_result by op_q: 0 and_acc, 1 ~and_acc, 2 or_acc, 3 ~or_acc, 4 xor_acc, 5 ~xor_acc.
  - Reserved op_q (6, 7): m_result=0, m_err=1. Otherwise m_err=0.
- Latency: the result is visible the cycle after the last beat is accepted.
- HOLD:
  - Outputs stay stable while m_ready=0, for unbounded backpressure.
  - On m_valid && m_ready: go to IDLE and drop m_valid next cycle. s_ready returns to 1 that same cycle.
- Throughput: there is no same-cycle bypass. Back-to-back single-beat frames take 2 cycles each when m_ready is tied high.
- Stable-payload rule: m_result, m_beats and m_err change only when entering HOLD or on rst. After m_valid drops they keep their last value.
- Reset mid-frame (ACCUM) or mid-HOLD discards the partial frame and any pending result. No m_valid is produced for it.
- Idle input: s_valid=0 in ACCUM leaves the state and accumulators unchanged, so gaps between beats are legal.
- s_last with s_valid=0 is ignored.
- Equivalence check: a one-beat frame with op=3 must equal the combinational ~(|s_data).

Test Plan:
1. N=8, op=3 (NOR), one beat 0x00 with s_last=1, m_ready=1 -> next cycle m_valid=1, m_result=1, m_beats=1, m_err=0. The following cycle m_valid=0 and s_ready=1.
2. op=3, three beats 0x00, 0x00, 0x10 (last), with a 2-cycle s_valid gap after beat 1 -> m_result=0, m_beats=3. Repeat with 0x10 replaced by 0x00 -> m_result=1.
3. op=4 (XOR) on beats 0x01, 0x03, 0x80 (last), with op driven to 0 on beats 2-3 -> m_result=0 (parity of 4 ones), m_beats=3, showing op is latched on the first beat. op=5 on the same frame -> 1.
4. Backpressure: complete a frame with op=0 on 0xFF, 0xFF (last), hold m_ready=0 for 5 cycles -> m_valid, m_result=1 and m_beats=2 stay stable; s_ready=0 throughout. A new s_valid beat is not accepted until the cycle after m_ready=1.
5. Reset mid-frame: two beats accepted, no s_last, then rst=1 for 1 cycle -> m_valid=0, m_beats=0, s_ready=1 after reset. A new 1-beat op=2 frame with data 0x04 -> m_result=1, m_beats=1.
6. Reserved op=6, beat 0xFF last -> m_err=1, m_result=0. With CW=2, a 5-beat op=2 frame -> m_beats=3 (saturated).

Source files
------------

// File: rtl/stream_unary_reduce_if.sv
// Stream port bundle for stream_unary_reduce: framed operand beats in,
// registered reduction result out.
interface stream_unary_reduce_if #(
  parameter int N  = 8,
  parameter int CW = 16
);
  logic [2:0]    op;
  logic          s_valid;
  logic          s_ready;
  logic [N-1:0]  s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic          m_result;
  logic [CW-1:0] m_beats;
  logic          m_err;

  modport slave (
    input  op, s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_result, m_beats, m_err
  );

  modport master (
    output op, s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_result, m_beats, m_err
  );
endinterface

// File: rtl/stream_unary_reduce.sv
// Multi-beat unary reduction (AND/NAND/OR/NOR/XOR/XNOR) over a framed stream,
// one registered result per frame with valid/ready output and saturating beat count.
module stream_unary_reduce #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input logic                   clk,
  input logic                   rst,
  stream_unary_reduce_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    r_state;
  logic [2:0]    r_op;
  logic          r_and;
  logic          r_or;
  logic          r_xor;
  logic [CW-1:0] r_cnt;
  logic          r_mvalid;
  logic          r_mresult;
  logic [CW-1:0] r_mbeats;
  logic          r_merr;

  logic          w_accept;
  logic          w_first;
  logic [2:0]    w_op;
  logic          w_and;
  logic          w_or;
  logic          w_xor;
  logic [CW-1:0] w_cnt;
  logic          w_result;
  logic          w_err;

  assign bus.s_ready  = ~rst & (r_state != S_HOLD);
  assign bus.m_valid  = r_mvalid;
  assign bus.m_result = r_mresult;
  assign bus.m_beats  = r_mbeats;
  assign bus.m_err    = r_merr;

  assign w_accept = bus.s_valid & bus.s_ready;

  // The first beat seeds the accumulators, so the previous frame's values never leak in.
  always_comb begin
    w_first = (r_state == S_IDLE);
    w_op    = w_first ? bus.op : r_op;
    w_and   = (w_first | r_and) & (&bus.s_data);
    w_or    = (~w_first & r_or) | (|bus.s_data);
    w_xor   = (~w_first & r_xor) ^ (^bus.s_data);
    if (w_first)
      w_cnt = CNT_ONE;
    else if (r_cnt == CNT_MAX)
      w_cnt = r_cnt;
    else
      w_cnt = r_cnt + CNT_ONE;
  end

  always_comb begin
    w_result = 1'b0;
    w_err    = 1'b0;
    case (w_op)
      3'd0:    w_result = w_and;
      3'd1:    w_result = ~w_and;
      3'd2:    w_result = w_or;
      3'd3:    w_result = ~w_or;
      3'd4:    w_result = w_xor;
      3'd5:    w_result = ~w_xor;
      default: w_err    = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_and     <= 1'b0;
      r_or      <= 1'b0;
      r_xor     <= 1'b0;
      r_cnt     <= '0;
      r_mvalid  <= 1'b0;
      r_mresult <= 1'b0;
      r_mbeats  <= '0;
      r_merr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            r_op  <= w_op;
            r_and <= w_and;
            r_or  <= w_or;
            r_xor <= w_xor;
            r_cnt <= w_cnt;
            if (bus.s_last) begin
              r_state   <= S_HOLD;
              r_mvalid  <= 1'b1;
              r_mresult <= w_result;
              r_mbeats  <= w_cnt;
              r_merr    <= w_err;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (bus.m_ready) begin
            r_state  <= S_IDLE;
            r_mvalid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_unary_reduce.sv
// Directed bench for stream_unary_reduce: an N=8/CW=16 instance for the main
// behaviour and an N=8/CW=2 instance for beat-count saturation.
module tb_stream_unary_reduce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  stream_unary_reduce_if #(.N(8), .CW(16)) a ();
  stream_unary_reduce_if #(.N(8), .CW(2))  b ();

  stream_unary_reduce #(.N(8), .CW(16)) dut_a (.clk(clk), .rst(rst), .bus(a));
  stream_unary_reduce #(.N(8), .CW(2))  dut_b (.clk(clk), .rst(rst), .bus(b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic [2:0] o);
    a.s_valid = 1'b1;
    a.s_data  = d;
    a.s_last  = l;
    a.op      = o;
    chk("s_ready_at_beat", a.s_ready, 1);
    tick();
    a.s_valid = 1'b0;
    a.s_last  = 1'b0;
    a.s_data  = '0;
  endtask

  task automatic result(input string tag, input logic res, input logic [15:0] beats, input logic err);
    chk({tag, "_valid"}, a.m_valid, 1);
    chk({tag, "_result"}, a.m_result, res);
    chk({tag, "_beats"}, a.m_beats, beats);
    chk({tag, "_err"}, a.m_err, err);
  endtask

  task automatic drain(input string tag);
    tick();
    chk({tag, "_drop"}, a.m_valid, 0);
    chk({tag, "_ready"}, a.s_ready, 1);
  endtask

  initial begin
    a.op = '0; a.s_valid = 1'b0; a.s_data = '0; a.s_last = 1'b0; a.m_ready = 1'b1;
    b.op = '0; b.s_valid = 1'b0; b.s_data = '0; b.s_last = 1'b0; b.m_ready = 1'b1;

    // reset state
    repeat (2) tick();
    chk("rst_s_ready", a.s_ready, 0);
    chk("rst_m_valid", a.m_valid, 0);
    chk("rst_m_beats", a.m_beats, 0);
    chk("rst_m_result", a.m_result, 0);
    chk("rst_m_err", a.m_err, 0);
    chk("rst_b_m_valid", b.m_valid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", a.s_ready, 1);

    // 1: single-beat NOR of zero
    beat(8'h00, 1'b1, 3'd3);
    result("t1", 1'b1, 16'd1, 1'b0);
    chk("t1_s_ready_hold", a.s_ready, 0);
    drain("t1");
    chk("t1_payload_kept", a.m_result, 1);

    // 2: NOR with gap after first beat
    beat(8'h00, 1'b0, 3'd3);
    repeat (2) tick();
    beat(8'h00, 1'b0, 3'd3);
    beat(8'h10, 1'b1, 3'd3);
    result("t2a", 1'b0, 16'd3, 1'b0);
    drain("t2a");
    beat(8'h00, 1'b0, 3'd3);
    repeat (2) tick();
    beat(8'h00, 1'b0, 3'd3);
    beat(8'h00, 1'b1, 3'd3);
    result("t2b", 1'b1, 16'd3, 1'b0);
    drain("t2b");

    // 3: XOR/XNOR parity, op only taken from the first beat
    beat(8'h01, 1'b0, 3'd4);
    beat(8'h03, 1'b0, 3'd0);
    beat(8'h80, 1'b1, 3'd0);
    result("t3_xor", 1'b0, 16'd3, 1'b0);
    drain("t3_xor");
    beat(8'h01, 1'b0, 3'd5);
    beat(8'h03, 1'b0, 3'd0);
    beat(8'h80, 1'b1, 3'd0);
    result("t3_xnor", 1'b1, 16'd3, 1'b0);
    drain("t3_xnor");

    // 4: backpressure with a waiting beat
    a.m_ready = 1'b0;
    beat(8'hFF, 1'b0, 3'd0);
    beat(8'hFF, 1'b1, 3'd0);
    a.s_valid = 1'b1; a.s_data = 8'h00; a.s_last = 1'b1; a.op = 3'd2;
    for (int i = 0; i < 5; i++) begin
      result("t4_hold", 1'b1, 16'd2, 1'b0);
      chk("t4_s_ready_low", a.s_ready, 0);
      tick();
    end
    a.m_ready = 1'b1;
    tick();
    chk("t4_release_drop", a.m_valid, 0);
    chk("t4_release_ready", a.s_ready, 1);
    chk("t4_release_payload", a.m_beats, 2);
    tick();
    a.s_valid = 1'b0; a.s_last = 1'b0;
    result("t4_next", 1'b0, 16'd1, 1'b0);
    drain("t4_next");

    // 5: reset mid-frame discards the partial frame
    beat(8'hAA, 1'b0, 3'd1);
    beat(8'h55, 1'b0, 3'd1);
    rst = 1'b1;
    tick();
    chk("t5_rst_s_ready", a.s_ready, 0);
    rst = 1'b0;
    #1;
    chk("t5_m_valid", a.m_valid, 0);
    chk("t5_m_beats", a.m_beats, 0);
    chk("t5_s_ready", a.s_ready, 1);
    tick();
    chk("t5_no_result", a.m_valid, 0);
    beat(8'h04, 1'b1, 3'd2);
    result("t5_or", 1'b1, 16'd1, 1'b0);
    drain("t5_or");

    // 6: reserved op, then a legal op clears the error flag
    beat(8'hFF, 1'b1, 3'd6);
    result("t6_rsvd", 1'b0, 16'd1, 1'b1);
    drain("t6_rsvd");
    beat(8'h00, 1'b1, 3'd5);
    result("t6_xnor", 1'b1, 16'd1, 1'b0);
    drain("t6_xnor");

    // 6: CW=2 beat count saturates at 3
    for (int i = 0; i < 5; i++) begin
      b.s_valid = 1'b1;
      b.s_data  = (i == 2) ? 8'h01 : 8'h00;
      b.s_last  = (i == 4);
      b.op      = 3'd2;
      chk("t6_sat_s_ready", b.s_ready, 1);
      tick();
    end
    b.s_valid = 1'b0; b.s_last = 1'b0;
    chk("t6_sat_valid", b.m_valid, 1);
    chk("t6_sat_beats", b.m_beats, 3);
    chk("t6_sat_result", b.m_result, 1);
    chk("t6_sat_err", b.m_err, 0);
    tick();
    chk("t6_sat_drop", b.m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
